// File: rtl/peak_decim_ctrl_if.sv
// Handshake/bus bundle for peak_decim_ctrl.
// master = host/trigger + datapath side, slave = the sequencer.
interface peak_decim_ctrl_if #(
  parameter int ADDR_W = 19,
  parameter int DIV_W  = 16
);
  logic              START;
  logic              STOP;
  logic              LA_SOURSE;
  logic [DIV_W-1:0]  DECIM;
  logic [ADDR_W-1:0] LENGTH;
  logic              MIN_MAX_LOAD;
  logic              SRAM_WE;
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic              WR_SEL;
  logic              BUSY;
  logic              DONE;

  modport master (
    output START, STOP, LA_SOURSE, DECIM, LENGTH,
    input  MIN_MAX_LOAD, SRAM_WE, SRAM_ADDR,
    input  WR_SEL, BUSY, DONE
  );

  modport slave (
    input  START, STOP, LA_SOURSE, DECIM, LENGTH,
    output MIN_MAX_LOAD, SRAM_WE, SRAM_ADDR,
    output WR_SEL, BUSY, DONE
  );
endinterface

// File: rtl/peak_decim_ctrl.sv
// Capture sequencer for the min/max peak-detect datapath.
// Ports: CLK, RESET_N (async low), bus (slave): START/STOP/LA_SOURSE/
// DECIM/LENGTH in; MIN_MAX_LOAD/SRAM_WE/SRAM_ADDR/WR_SEL/BUSY/DONE out.
module peak_decim_ctrl #(
  parameter int ADDR_W = 19,
  parameter int DIV_W  = 16
) (
  input  logic           CLK,
  input  logic           RESET_N,
  peak_decim_ctrl_if.slave bus
);

  localparam int CW = ADDR_W + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  lim_q;
  logic [DIV_W-1:0]  cnt;
  logic              peak_q;
  logic [CW-1:0]     len_q;
  logic [CW-1:0]     sched;
  logic [CW-1:0]     wcnt;
  logic [ADDR_W-1:0] aptr;
  logic              ld_d1;
  logic              ld_max;

  logic              load_q;
  logic              we_q;
  logic              sel_q;
  logic [ADDR_W-1:0] addr_q;
  logic              busy_q;
  logic              done_q;

  logic [DIV_W-1:0]  lim_in;
  logic [DIV_W-1:0]  cnt_nx;
  logic [CW-1:0]     len_in;
  logic              load_nx;
  logic              max_nx;
  logic              we_nx;
  logic              last_wr;

  // sched counts writes already committed by issued loads, so a load
  // is only issued while at least one of its writes is still needed.
  always_comb begin
    lim_in = bus.DECIM;
    if (!bus.LA_SOURSE && bus.DECIM == '0)
      lim_in = DIV_W'(1);
    len_in = {2'b00, bus.LENGTH};
    if (bus.LENGTH == '0)
      len_in = CW'(1) << ADDR_W;
    cnt_nx  = (cnt == lim_q) ? '0 : cnt + DIV_W'(1);
    load_nx = (cnt_nx == '0) && (sched < len_q);
    max_nx  = load_q & ld_max;
    we_nx   = max_nx | ld_d1;
    last_wr = we_q && (wcnt == len_q);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= S_IDLE;
      lim_q  <= '0;
      cnt    <= '0;
      peak_q <= 1'b0;
      len_q  <= '0;
      sched  <= '0;
      wcnt   <= '0;
      aptr   <= '0;
      ld_d1  <= 1'b0;
      ld_max <= 1'b0;
      load_q <= 1'b0;
      we_q   <= 1'b0;
      sel_q  <= 1'b0;
      addr_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.START) begin
            state  <= S_RUN;
            lim_q  <= lim_in;
            peak_q <= !bus.LA_SOURSE;
            len_q  <= len_in;
            // first load goes out with the RUN entry
            cnt    <= '0;
            sched  <= CW'(1);
            wcnt   <= '0;
            aptr   <= '0;
            load_q <= 1'b1;
            ld_max <= 1'b0;
            ld_d1  <= 1'b0;
            we_q   <= 1'b0;
            sel_q  <= 1'b0;
            addr_q <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
          end
        end
        S_RUN: begin
          if (bus.STOP || last_wr) begin
            state  <= bus.STOP ? S_IDLE : S_DONE;
            done_q <= !bus.STOP;
            busy_q <= 1'b0;
            load_q <= 1'b0;
            we_q   <= 1'b0;
            sel_q  <= 1'b0;
            addr_q <= '0;
            ld_d1  <= 1'b0;
            ld_max <= 1'b0;
          end else begin
            cnt    <= cnt_nx;
            load_q <= load_nx;
            if (load_nx) begin
              ld_max <= peak_q;
              sched  <= sched + (peak_q ? CW'(2) : CW'(1));
            end
            // min/sample word two cycles after load,
            // max of previous window one cycle after
            ld_d1 <= load_q;
            we_q  <= we_nx;
            sel_q <= max_nx;
            if (we_nx) begin
              addr_q <= aptr;
              aptr   <= aptr + ADDR_W'(1);
              wcnt   <= wcnt + CW'(1);
            end
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          done_q <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.MIN_MAX_LOAD = load_q;
  assign bus.SRAM_WE      = we_q;
  assign bus.SRAM_ADDR    = addr_q;
  assign bus.WR_SEL       = sel_q;
  assign bus.BUSY         = busy_q;
  assign bus.DONE         = done_q;

endmodule

// File: tb/tb_peak_decim_ctrl.sv
// Randomized self-checking bench for peak_decim_ctrl.
// Expected per-cycle outputs come from a window/write schedule model.
module tb_peak_decim_ctrl;

  localparam int MAXC = 256;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLK = ~CLK;

  peak_decim_ctrl_if #(.ADDR_W(19), .DIV_W(16)) b19 ();
  peak_decim_ctrl_if #(.ADDR_W(4), .DIV_W(16)) b4 ();

  peak_decim_ctrl #(.ADDR_W(19), .DIV_W(16)) u_dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .bus(b19)
  );

  peak_decim_ctrl #(.ADDR_W(4), .DIV_W(16)) u_dut4 (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .bus(b4)
  );

  logic        sel4 = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        la = 1'b0;
  logic [15:0] dec = '0;
  logic [18:0] lng = '0;

  assign b19.START     = start & ~sel4;
  assign b4.START      = start & sel4;
  assign b19.STOP      = stop;
  assign b4.STOP       = stop;
  assign b19.LA_SOURSE = la;
  assign b4.LA_SOURSE  = la;
  assign b19.DECIM     = dec;
  assign b4.DECIM      = dec;
  assign b19.LENGTH    = lng;
  assign b4.LENGTH     = lng[3:0];

  logic        o_load, o_we, o_sel, o_busy, o_done;
  logic [18:0] o_addr;
  assign o_load = sel4 ? b4.MIN_MAX_LOAD : b19.MIN_MAX_LOAD;
  assign o_we   = sel4 ? b4.SRAM_WE : b19.SRAM_WE;
  assign o_sel  = sel4 ? b4.WR_SEL : b19.WR_SEL;
  assign o_busy = sel4 ? b4.BUSY : b19.BUSY;
  assign o_done = sel4 ? b4.DONE : b19.DONE;
  assign o_addr = sel4 ? {15'b0, b4.SRAM_ADDR} : b19.SRAM_ADDR;

  int vectors = 0;
  int miscompares = 0;
  int cur_c = 0;

  bit e_load [MAXC];
  bit e_we   [MAXC];
  bit e_sel  [MAXC];
  bit e_busy [MAXC];
  bit e_done [MAXC];
  int e_addr [MAXC];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h expected %0h",
               tag, cur_c, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_load"}, o_load, 0);
    chk({tag, "_we"}, o_we, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_addr"}, o_addr, 0);
  endtask

  // Schedule: load k at 1+k*Wd; peak mode writes max of the previous
  // window at L+1 (not for k=0) and min at L+2; sample mode writes at
  // L+2. Loads stop once every needed word has a producer.
  task automatic run(input bit use4, input bit peak, input int decim,
                     input int len, input int stop_c);
    int aw, lm, wd, nw, last, l, ncyc, endrun;
    aw = use4 ? 4 : 19;
    lm = len % (1 << aw);
    if (lm == 0) lm = 1 << aw;
    for (int c = 0; c < MAXC; c++) begin
      e_load[c] = 0; e_we[c] = 0; e_sel[c] = 0;
      e_busy[c] = 0; e_done[c] = 0; e_addr[c] = 0;
    end
    wd = decim + 1;
    if (peak && wd < 2) wd = 2;
    nw = 0;
    last = 0;
    for (int k = 0; nw < lm; k++) begin
      l = 1 + k * wd;
      e_load[l] = 1;
      if (peak && k > 0) begin
        e_we[l+1] = 1; e_sel[l+1] = 1;
        e_addr[l+1] = nw % (1 << aw);
        nw++; last = l + 1;
      end
      if (nw < lm) begin
        e_we[l+2] = 1; e_sel[l+2] = 0;
        e_addr[l+2] = nw % (1 << aw);
        nw++; last = l + 2;
      end
    end
    for (int c = 1; c <= last; c++) e_busy[c] = 1;
    e_done[last+1] = 1;
    endrun = last;
    if (stop_c >= 1 && stop_c <= last) begin
      for (int c = stop_c + 1; c < MAXC; c++) begin
        e_load[c] = 0; e_we[c] = 0; e_sel[c] = 0;
        e_busy[c] = 0; e_done[c] = 0; e_addr[c] = 0;
      end
      endrun = stop_c;
    end
    ncyc = endrun + 4;

    @(negedge CLK);
    sel4 = use4;
    la = !peak;
    dec = 16'(decim);
    lng = 19'(len);
    start = 1'b1;
    stop = 1'b0;
    @(posedge CLK); #1;
    for (int c = 1; c <= ncyc; c++) begin
      cur_c = c;
      chk("load", o_load, e_load[c]);
      chk("we", o_we, e_we[c]);
      chk("busy", o_busy, e_busy[c]);
      chk("done", o_done, e_done[c]);
      if (e_we[c] || !e_busy[c]) begin
        chk("addr", o_addr, e_addr[c]);
        chk("wr_sel", o_sel, e_sel[c]);
      end
      // shadowed inputs are scrambled while the run is in flight
      dec = 16'($urandom_range(0, 65535));
      lng = 19'($urandom);
      la = 1'($urandom);
      start = (c <= endrun) ? 1'($urandom) : 1'b0;
      if (c == stop_c)
        stop = 1'b1;
      else if (stop_c < 0 && c > endrun)
        stop = 1'($urandom);
      else
        stop = 1'b0;
      @(posedge CLK); #1;
    end
    start = 1'b0;
    stop = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    cur_c = 0;
    sel4 = 1'b0;
    chk_idle("rst19");
    sel4 = 1'b1;
    #1;
    chk_idle("rst4");
    @(negedge CLK);
    RESET_N = 1'b1;

    run(0, 1, 3, 6, -1);
    run(0, 0, 0, 4, -1);
    run(0, 1, 0, 2, -1);
    run(0, 1, 3, 6, 8);
    run(1, 0, 0, 0, -1);

    // async reset in the middle of a 16-word run
    @(negedge CLK);
    sel4 = 1'b1;
    la = 1'b1;
    dec = '0;
    lng = '0;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    cur_c = 6;
    chk("pre_rst_we", o_we, 1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk_idle("midrst");
    @(negedge CLK);
    RESET_N = 1'b1;
    run(1, 0, 0, 0, -1);

    for (int i = 0; i < 25; i++) begin
      run(0, 1'($urandom), $urandom_range(0, 6), $urandom_range(1, 12),
          ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : -1);
    end
    for (int i = 0; i < 6; i++) begin
      run(1, 1'($urandom), $urandom_range(0, 4), $urandom_range(0, 15),
          -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
